// File: rtl/uart_fifo_controller.sv
`default_nettype none
// ============================================================================
// Module  : uart_fifo_controller
// Brief   : Full-duplex UART with RX show-ahead FIFO, optional parity and
//           ASCII-digit decode, single-byte TX; processor-width read words.
// Rev     : 1.0  initial release
// ============================================================================
module uart_fifo_controller #(
    parameter int DATA_WIDTH   = 32,
    parameter int UART_NBIT    = 8,
    parameter int CLK_FREQ     = 50,
    parameter int BAUDRATE     = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int ASCII_DECODE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SerialDataIn,
    output logic                  SerialDataOut,
    input  logic                  rx_pop,
    input  logic                  tx_wr,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] uart_tx,
    output logic [DATA_WIDTH-1:0] UART_data,
    output logic [DATA_WIDTH-1:0] Rx_flag_out,
    output logic [DATA_WIDTH-1:0] Status_out
);
    localparam int c_clks_per_bit = CLK_FREQ / BAUDRATE;
    localparam int c_cnt_w        = $clog2(c_clks_per_bit);
    localparam int c_bit_w        = $clog2(UART_NBIT);
    localparam int c_ptr_w        = $clog2(FIFO_DEPTH);

    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_clks_per_bit - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_clks_per_bit / 2 - 1);
    localparam logic [c_bit_w-1:0] c_nbit_last = c_bit_w'(UART_NBIT - 1);
    localparam logic [c_ptr_w:0]   c_fifo_full = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic               c_par_en    = (PARITY_EN != 0);
    localparam logic               c_par_odd   = (PARITY_ODD != 0);
    localparam logic               c_ascii     = (ASCII_DECODE != 0);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_start  = 3'd1;
    localparam logic [2:0] c_s_data   = 3'd2;
    localparam logic [2:0] c_s_parity = 3'd3;
    localparam logic [2:0] c_s_stop   = 3'd4;

    // ---------------- RX ----------------
    logic                 r_rx_sync1, r_rx_sync2, r_rx_prev;
    logic [2:0]           r_rx_state, w_rx_state_nxt;
    logic [c_cnt_w-1:0]   r_rx_cnt, w_rx_cnt_nxt;
    logic [c_bit_w-1:0]   r_rx_bit, w_rx_bit_nxt;
    logic [UART_NBIT-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                 r_rx_par, w_rx_par_nxt;
    logic                 w_frame_done;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_par_nxt   = r_rx_par;
        w_frame_done   = 1'b0;
        case (r_rx_state)
            c_s_idle: begin
                if (r_rx_prev && !r_rx_sync2) begin
                    w_rx_state_nxt = c_s_start;
                    w_rx_cnt_nxt   = '0;
                end
            end
            c_s_start: begin
                if (r_rx_cnt == c_half_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = '0;
                    // a line already back high at mid start bit was a glitch
                    w_rx_state_nxt = r_rx_sync2 ? c_s_idle : c_s_data;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            c_s_data: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_sync2, r_rx_shift[UART_NBIT-1:1]};
                    if (r_rx_bit == c_nbit_last)
                        w_rx_state_nxt = c_par_en ? c_s_parity : c_s_stop;
                    else
                        w_rx_bit_nxt = r_rx_bit + 1'b1;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            c_s_parity: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_par_nxt   = r_rx_sync2;
                    w_rx_state_nxt = c_s_stop;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            c_s_stop: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_frame_done   = 1'b1;
                    w_rx_state_nxt = c_s_idle;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_state_nxt = c_s_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= c_s_idle;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
        end else begin
            r_rx_sync1 <= SerialDataIn;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_par   <= w_rx_par_nxt;
        end
    end

    logic [7:0] w_rx_ext, w_rx_dec;
    logic       w_par_bad, w_frame_err_set, w_par_err_set, w_push_req;

    always_comb begin
        w_rx_ext                  = '0;
        w_rx_ext[UART_NBIT-1:0]   = r_rx_shift;
        w_rx_dec                  = w_rx_ext;
        if (c_ascii && (w_rx_ext >= 8'h30) && (w_rx_ext <= 8'h39))
            w_rx_dec = w_rx_ext - 8'h30;
    end

    assign w_par_bad       = c_par_en && (r_rx_par != ((^r_rx_shift) ^ c_par_odd));
    assign w_frame_err_set = w_frame_done && !r_rx_sync2;
    assign w_par_err_set   = w_frame_done && r_rx_sync2 && w_par_bad;
    assign w_push_req      = w_frame_done && r_rx_sync2 && !w_par_bad;

    // ---------------- FIFO + sticky status ----------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               r_overrun, r_par_err, r_frame_err;
    logic               w_empty, w_full, w_do_pop, w_do_push, w_overrun_set;

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == c_fifo_full);
    assign w_do_pop      = rx_pop && !w_empty;
    // a pop in the same cycle frees the slot a full FIFO needs
    assign w_do_push     = w_push_req && (!w_full || w_do_pop);
    assign w_overrun_set = w_push_req && w_full && !w_do_pop;

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= w_rx_dec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overrun   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_overrun_set)   r_overrun   <= 1'b1;
            else if (clr_err)    r_overrun   <= 1'b0;
            if (w_par_err_set)   r_par_err   <= 1'b1;
            else if (clr_err)    r_par_err   <= 1'b0;
            if (w_frame_err_set) r_frame_err <= 1'b1;
            else if (clr_err)    r_frame_err <= 1'b0;
        end
    end

    // ---------------- TX ----------------
    logic [2:0]           r_tx_state, w_tx_state_nxt;
    logic [c_cnt_w-1:0]   r_tx_cnt, w_tx_cnt_nxt;
    logic [c_bit_w-1:0]   r_tx_bit, w_tx_bit_nxt;
    logic [UART_NBIT-1:0] r_tx_shift, w_tx_shift_nxt;
    logic                 r_tx_par, w_tx_par_nxt;
    logic                 w_tx_bit_end, w_tx_busy;
    logic                 w_unused_tx;

    assign w_unused_tx  = ^uart_tx[DATA_WIDTH-1:UART_NBIT];
    assign w_tx_bit_end = (r_tx_cnt == c_bit_last);
    assign w_tx_busy    = (r_tx_state != c_s_idle);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        case (r_tx_state)
            c_s_idle: begin
                w_tx_cnt_nxt = '0;
                if (tx_wr) begin
                    w_tx_state_nxt = c_s_start;
                    w_tx_shift_nxt = uart_tx[UART_NBIT-1:0];
                    w_tx_par_nxt   = (^uart_tx[UART_NBIT-1:0]) ^ c_par_odd;
                end
            end
            c_s_start: begin
                if (w_tx_bit_end) begin
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = c_s_data;
                end
            end
            c_s_data: begin
                if (w_tx_bit_end) begin
                    w_tx_shift_nxt = {1'b0, r_tx_shift[UART_NBIT-1:1]};
                    if (r_tx_bit == c_nbit_last)
                        w_tx_state_nxt = c_par_en ? c_s_parity : c_s_stop;
                    else
                        w_tx_bit_nxt = r_tx_bit + 1'b1;
                end
            end
            c_s_parity: if (w_tx_bit_end) w_tx_state_nxt = c_s_stop;
            c_s_stop:   if (w_tx_bit_end) w_tx_state_nxt = c_s_idle;
            default:    w_tx_state_nxt = c_s_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= c_s_idle;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
        end
    end

    always_comb begin
        case (r_tx_state)
            c_s_start:  SerialDataOut = 1'b0;
            c_s_data:   SerialDataOut = r_tx_shift[0];
            c_s_parity: SerialDataOut = r_tx_par;
            default:    SerialDataOut = 1'b1;
        endcase
    end

    // ---------------- processor-facing words ----------------
    always_comb begin
        UART_data   = '0;
        Rx_flag_out = '0;
        Status_out  = '0;
        if (!w_empty)
            UART_data[7:0] = r_mem[r_rd_ptr];
        Rx_flag_out[0] = !w_empty;
        Status_out[0]  = !w_empty;
        Status_out[1]  = w_full;
        Status_out[2]  = r_overrun;
        Status_out[3]  = r_par_err;
        Status_out[4]  = r_frame_err;
        Status_out[5]  = w_tx_busy;
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_fifo_controller
// Brief   : Directed self-checking bench: RX table plus TX/parity/reset cases.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_fifo_controller;
    localparam int c_op_send   = 0;
    localparam int c_op_pop    = 1;
    localparam int c_op_clr    = 2;
    localparam int c_op_glitch = 3;
    localparam int c_nv        = 24;

    typedef struct {
        int          op;
        logic [7:0]  dat;
        logic        stop;
        logic [31:0] exp_data;
        logic [31:0] exp_status;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, reset_p;
    logic        serial_in, serial_in_p, serial_out, serial_out_p;
    logic        rx_pop, rx_pop_p, tx_wr, tx_wr_p, clr_err, clr_err_p;
    logic [31:0] uart_tx, uart_tx_p;
    logic [31:0] uart_data, rx_flag, status;
    logic [31:0] uart_data_p, rx_flag_p, status_p;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_fifo_controller u_dut (
        .clk(clk), .reset(reset), .SerialDataIn(serial_in), .SerialDataOut(serial_out),
        .rx_pop(rx_pop), .tx_wr(tx_wr), .clr_err(clr_err), .uart_tx(uart_tx),
        .UART_data(uart_data), .Rx_flag_out(rx_flag), .Status_out(status)
    );

    uart_fifo_controller #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
        .clk(clk), .reset(reset_p), .SerialDataIn(serial_in_p), .SerialDataOut(serial_out_p),
        .rx_pop(rx_pop_p), .tx_wr(tx_wr_p), .clr_err(clr_err_p), .uart_tx(uart_tx_p),
        .UART_data(uart_data_p), .Rx_flag_out(rx_flag_p), .Status_out(status_p)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic sel, input logic v);
        if (sel) serial_in_p = v;
        else     serial_in   = v;
        repeat (10) tick();
    endtask

    task automatic send_frame(input logic sel, input logic [7:0] b, input logic use_par,
                              input logic par, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
        if (use_par) drive_bit(sel, par);
        drive_bit(sel, stop);
        if (sel) serial_in_p = 1'b1;
        else     serial_in   = 1'b1;
    endtask

    vec_t       vecs [c_nv];
    logic [9:0] exp_line;
    int         busy_cnt;
    bit         found;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{c_op_send,   8'h37, 1'b1, 32'h07, 32'h01};
        vecs[1]  = '{c_op_pop,    8'h00, 1'b1, 32'h00, 32'h00};
        vecs[2]  = '{c_op_send,   8'h41, 1'b1, 32'h41, 32'h01};
        vecs[3]  = '{c_op_send,   8'h42, 1'b1, 32'h41, 32'h01};
        vecs[4]  = '{c_op_send,   8'h43, 1'b1, 32'h41, 32'h01};
        vecs[5]  = '{c_op_send,   8'h44, 1'b1, 32'h41, 32'h03};
        vecs[6]  = '{c_op_send,   8'h45, 1'b1, 32'h41, 32'h07};
        vecs[7]  = '{c_op_pop,    8'h00, 1'b1, 32'h42, 32'h05};
        vecs[8]  = '{c_op_pop,    8'h00, 1'b1, 32'h43, 32'h05};
        vecs[9]  = '{c_op_pop,    8'h00, 1'b1, 32'h44, 32'h05};
        vecs[10] = '{c_op_pop,    8'h00, 1'b1, 32'h00, 32'h04};
        vecs[11] = '{c_op_pop,    8'h00, 1'b1, 32'h00, 32'h04};
        vecs[12] = '{c_op_clr,    8'h00, 1'b1, 32'h00, 32'h00};
        vecs[13] = '{c_op_send,   8'h30, 1'b1, 32'h00, 32'h01};
        vecs[14] = '{c_op_send,   8'h38, 1'b0, 32'h00, 32'h11};
        vecs[15] = '{c_op_clr,    8'h00, 1'b1, 32'h00, 32'h01};
        vecs[16] = '{c_op_pop,    8'h00, 1'b1, 32'h00, 32'h00};
        vecs[17] = '{c_op_glitch, 8'h00, 1'b1, 32'h00, 32'h00};
        vecs[18] = '{c_op_send,   8'h39, 1'b1, 32'h09, 32'h01};
        vecs[19] = '{c_op_send,   8'h3A, 1'b1, 32'h09, 32'h01};
        vecs[20] = '{c_op_pop,    8'h00, 1'b1, 32'h3A, 32'h01};
        vecs[21] = '{c_op_pop,    8'h00, 1'b1, 32'h00, 32'h00};
        vecs[22] = '{c_op_send,   8'h2F, 1'b1, 32'h2F, 32'h01};
        vecs[23] = '{c_op_pop,    8'h00, 1'b1, 32'h00, 32'h00};

        reset = 1'b1; reset_p = 1'b1;
        serial_in = 1'b1; serial_in_p = 1'b1;
        rx_pop = 1'b0; rx_pop_p = 1'b0; tx_wr = 1'b0; tx_wr_p = 1'b0;
        clr_err = 1'b0; clr_err_p = 1'b0; uart_tx = '0; uart_tx_p = '0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_data",   uart_data, 32'h0);
        check("reset_flag",   rx_flag,   32'h0);
        check("reset_status", status,    32'h0);
        check("reset_txline", {31'b0, serial_out}, 32'h1);
        tick();
        reset = 1'b0; reset_p = 1'b0;
        tick();

        // RX / FIFO / sticky-flag table
        for (int v = 0; v < c_nv; v++) begin
            case (vecs[v].op)
                c_op_send: send_frame(1'b0, vecs[v].dat, 1'b0, 1'b0, vecs[v].stop);
                c_op_pop:  begin rx_pop = 1'b1; tick(); rx_pop = 1'b0; end
                c_op_clr:  begin clr_err = 1'b1; tick(); clr_err = 1'b0; end
                default: begin
                    serial_in = 1'b0; repeat (4) tick();
                    serial_in = 1'b1; repeat (12) tick();
                end
            endcase
            repeat (5) tick();
            @(negedge clk);
            check($sformatf("vec%0d_data", v),   uart_data, vecs[v].exp_data);
            check($sformatf("vec%0d_flag", v),   rx_flag,   {31'b0, vecs[v].exp_status[0]});
            check($sformatf("vec%0d_status", v), status,    vecs[v].exp_status);
        end

        // TX frame 0xA5, with an ignored second tx_wr mid-frame
        exp_line = 10'b1101001010;
        busy_cnt = 0;
        @(negedge clk);
        uart_tx = 32'h0000_00A5;
        tx_wr   = 1'b1;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            if (status[5]) busy_cnt++;
            if ((i % 10) == 5 && i <= 100)
                check($sformatf("tx_bit%0d", i / 10), {31'b0, serial_out}, {31'b0, exp_line[i / 10]});
            tx_wr   = (i == 30);
            uart_tx = (i == 30) ? 32'h0000_00FF : 32'h0000_00A5;
        end
        check("tx_busy_cycles", busy_cnt, 32'd100);
        check("tx_idle_line",   {31'b0, serial_out}, 32'h1);
        check("tx_idle_busy",   {31'b0, status[5]},  32'h0);

        // back-to-back: tx_wr on the first idle cycle after STOP
        uart_tx = 32'h0000_000F;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (!status[5]) begin found = 1'b1; break; end
        end
        check("b2b_first_done", {31'b0, found}, 32'h1);
        uart_tx = 32'h0;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        check("b2b_busy",  {31'b0, status[5]},  32'h1);
        check("b2b_start", {31'b0, serial_out}, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (!status[5]) begin found = 1'b1; break; end
        end
        check("b2b_second_done", {31'b0, found}, 32'h1);

        // parity instance: bad then good parity on 0x03 (even parity bit = 0)
        tick();
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        repeat (5) tick();
        @(negedge clk);
        check("par_bad_data",   uart_data_p, 32'h0);
        check("par_bad_flag",   rx_flag_p,   32'h0);
        check("par_bad_status", status_p,    32'h08);
        tick();
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        repeat (5) tick();
        @(negedge clk);
        check("par_good_data",   uart_data_p, 32'h03);
        check("par_good_status", status_p,    32'h09);

        // reset in the middle of both an RX and a TX frame
        uart_tx_p = 32'h0;
        tx_wr_p   = 1'b1;
        tick();
        tx_wr_p = 1'b0;
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b1);
        check("mid_tx_line", {31'b0, serial_out_p}, 32'h0);
        #2 reset_p = 1'b1;
        #1;
        check("rst_mid_data",   uart_data_p, 32'h0);
        check("rst_mid_flag",   rx_flag_p,   32'h0);
        check("rst_mid_status", status_p,    32'h0);
        check("rst_mid_txline", {31'b0, serial_out_p}, 32'h1);
        serial_in_p = 1'b1;
        repeat (3) tick();
        reset_p = 1'b0;
        repeat (150) tick();
        @(negedge clk);
        check("rst_no_partial", status_p, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
